// File: rtl/game_pkg.sv
// Shared definitions for the reaction game: controller state encoding and the
// hex display mode codes understood by the display driver.
package game_pkg;

  typedef enum logic [2:0] {
    StOff,
    StIdle,
    StArm,
    StFoul,
    StGo,
    StResult,
    StDone
  } game_state_e;

  // Display modes presented to the hex driver.
  localparam logic [2:0] HexBlank    = 3'b000;
  localparam logic [2:0] HexClick    = 3'b001;
  localparam logic [2:0] HexTooSoon  = 3'b010;
  localparam logic [2:0] HexTime     = 3'b100;
  localparam logic [2:0] HexTimeout  = 3'b101;
  localparam logic [2:0] HexGameOver = 3'b110;

  localparam int unsigned ScoreW   = 4;
  localparam logic [3:0]  ScoreMax = 4'hF;

  // Display mode shown while the controller sits in a given state.
  function automatic logic [2:0] hex_for_state(game_state_e st, logic timed_out);
    logic [2:0] mode;
    mode = HexBlank;
    case (st)
      StFoul:   mode = HexTooSoon;
      StGo:     mode = HexClick;
      StResult: mode = timed_out ? HexTimeout : HexTime;
      StDone:   mode = HexGameOver;
      default:  mode = HexBlank;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), advancing every clock.
// Seeded with 16'h0001 on reset; the sequence never reaches zero.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   out_o    current LFSR state
module lfsr16 (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [15:0] out_o
);

  localparam logic [15:0] TapMask = 16'hB400;

  logic [15:0] state_q, state_d;

  // Right-shifting Galois form: feedback from bit 0 toggles the tap positions.
  always_comb begin
    state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? TapMask : 16'h0000);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= 16'h0001;
    end else begin
      state_q <= state_d;
    end
  end

  assign out_o = state_q;

endmodule

// File: rtl/game1_reaction_multi.sv
// Multi-player, multi-round reaction game controller. Contains key
// synchronisers, the ms prescaler, random arm delay, reaction timer,
// false-start detection and per-player scoring.
// Ports:
//   clk_i            system clock
//   reset_i          synchronous active-high reset
//   switch_i         game enable; low forces OFF
//   key_i            player keys, active-low, asynchronous
//   go_led_o         high while in GO
//   hex_mode_o       display mode for the hex driver
//   reaction_time_o  last latched reaction time, ms
//   player_o         round winner / fouler / game winner, per hex_mode_o
//   scores_o         packed 4-bit per-player scores, player 0 in LSBs
//   round_num_o      rounds completed in the current game
//   game_over_o      high while in DONE
module game1_reaction_multi
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS      = 2,
  parameter int unsigned TIME_W           = 14,
  parameter int unsigned TICK_DIV         = 50000,
  parameter int unsigned DELAY_MIN_MS     = 1000,
  parameter int unsigned DELAY_RANGE_LOG2 = 11,   // 1..15
  parameter int unsigned TIMEOUT_MS       = 5000,
  parameter int unsigned ROUNDS           = 3,
  localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     switch_i,
  input  logic [NUM_PLAYERS-1:0]   key_i,
  output logic                     go_led_o,
  output logic [2:0]               hex_mode_o,
  output logic [TIME_W-1:0]        reaction_time_o,
  output logic [PW-1:0]            player_o,
  output logic [4*NUM_PLAYERS-1:0] scores_o,
  output logic [3:0]               round_num_o,
  output logic                     game_over_o
);

  localparam int unsigned PrescW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DelayW  = $clog2(DELAY_MIN_MS + (2 ** DELAY_RANGE_LOG2));
  localparam logic [TIME_W-1:0] TimeMax = '1;
  localparam logic [TIME_W-1:0] TimeOut = TIME_W'(TIMEOUT_MS);

  // ---------------------------------------------------------------------------
  // Key synchroniser and falling-edge detect
  // ---------------------------------------------------------------------------
  logic [NUM_PLAYERS-1:0] key_s1_q, key_s2_q, key_prev_q;
  logic [NUM_PLAYERS-1:0] press;
  logic                   any_press;

  // Flops reset to released (high) so no phantom press follows reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      key_prev_q <= '1;
    end else begin
      key_s1_q   <= key_i;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
    end
  end

  assign press     = key_prev_q & ~key_s2_q;
  assign any_press = |press;

  // Lowest pressed index wins simultaneous presses.
  logic [PW-1:0] first_idx;
  logic          first_found;
  always_comb begin
    first_idx   = '0;
    first_found = 1'b0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (press[i] && !first_found) begin
        first_found = 1'b1;
        first_idx   = PW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Random source
  // ---------------------------------------------------------------------------
  logic [15:0]       lfsr;
  logic [DelayW-1:0] delay_load;
  logic              unused_lfsr;

  lfsr16 u_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .out_o   (lfsr)
  );

  assign delay_load  = DelayW'(DELAY_MIN_MS) + DelayW'(lfsr[DELAY_RANGE_LOG2-1:0]);
  assign unused_lfsr = ^lfsr[15:DELAY_RANGE_LOG2];

  // ---------------------------------------------------------------------------
  // Game state and datapath
  // ---------------------------------------------------------------------------
  game_state_e              state_q, state_d;
  logic [PrescW-1:0]        presc_q, presc_d;
  logic [DelayW-1:0]        delay_q, delay_d;
  logic [TIME_W-1:0]        timer_q, timer_d;
  logic [TIME_W-1:0]        rtime_q, rtime_d;
  logic [PW-1:0]            win_q, win_d;
  logic [4*NUM_PLAYERS-1:0] scores_q, scores_d;
  logic [3:0]               round_q, round_d;
  logic                     timed_out_q, timed_out_d;
  logic                     tick;

  assign tick = (presc_q == PrescW'(TICK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    presc_d     = tick ? '0 : presc_q + PrescW'(1);
    delay_d     = delay_q;
    timer_d     = timer_q;
    rtime_d     = rtime_q;
    win_d       = win_q;
    scores_d    = scores_q;
    round_d     = round_q;
    timed_out_d = timed_out_q;

    if (!switch_i) begin
      state_d  = StOff;
      scores_d = '0;
      round_d  = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StIdle;
        end

        StIdle: begin
          if (any_press) begin
            state_d = StArm;
            delay_d = delay_load;
            presc_d = '0;
          end
        end

        StArm: begin
          // A false start beats delay expiry in the same cycle.
          if (any_press) begin
            state_d = StFoul;
            win_d   = first_idx;
          end else if (delay_q == '0) begin
            state_d = StGo;
            timer_d = '0;
            presc_d = '0;
          end else if (tick) begin
            delay_d = delay_q - DelayW'(1);
          end
        end

        StFoul: begin
          if (any_press) begin
            state_d = StArm;
            delay_d = delay_load;
            presc_d = '0;
          end
        end

        StGo: begin
          if (any_press) begin
            state_d     = StResult;
            win_d       = first_idx;
            rtime_d     = timer_q;
            round_d     = round_q + 4'd1;
            timed_out_d = 1'b0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
              if ((PW'(i) == first_idx) && (scores_q[4*i +: 4] != ScoreMax)) begin
                scores_d[4*i +: 4] = scores_q[4*i +: 4] + 4'd1;
              end
            end
          end else if (timer_q == TimeOut) begin
            state_d     = StResult;
            win_d       = '0;
            rtime_d     = TimeOut;
            round_d     = round_q + 4'd1;
            timed_out_d = 1'b1;
          end else if (tick && (timer_q != TimeMax)) begin
            timer_d = timer_q + TIME_W'(1);
          end
        end

        StResult: begin
          if (any_press) begin
            if (round_q == 4'(ROUNDS)) begin
              state_d = StDone;
            end else begin
              state_d = StArm;
              delay_d = delay_load;
              presc_d = '0;
            end
          end
        end

        StDone: begin
          if (any_press) begin
            state_d  = StIdle;
            scores_d = '0;
            round_d  = '0;
            rtime_d  = '0;
          end
        end

        default: state_d = StOff;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StOff;
      presc_q     <= '0;
      delay_q     <= '0;
      timer_q     <= '0;
      rtime_q     <= '0;
      win_q       <= '0;
      scores_q    <= '0;
      round_q     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      delay_q     <= delay_d;
      timer_q     <= timer_d;
      rtime_q     <= rtime_d;
      win_q       <= win_d;
      scores_q    <= scores_d;
      round_q     <= round_d;
      timed_out_q <= timed_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Game winner: highest score, ties resolved to the lowest index
  // ---------------------------------------------------------------------------
  logic [PW-1:0] best_idx;
  logic [3:0]    best_score;
  always_comb begin
    best_idx   = '0;
    best_score = scores_q[3:0];
    for (int unsigned i = 1; i < NUM_PLAYERS; i++) begin
      if (scores_q[4*i +: 4] > best_score) begin
        best_score = scores_q[4*i +: 4];
        best_idx   = PW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered display outputs, one clock behind the state
  // ---------------------------------------------------------------------------
  logic          go_led_q, game_over_q;
  logic [2:0]    hex_q;
  logic [PW-1:0] player_q, player_d;

  always_comb begin
    player_d = '0;
    if (state_q == StDone) begin
      player_d = best_idx;
    end else if ((state_q == StFoul) || (state_q == StResult)) begin
      player_d = win_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      go_led_q    <= 1'b0;
      game_over_q <= 1'b0;
      hex_q       <= HexBlank;
      player_q    <= '0;
    end else begin
      go_led_q    <= (state_q == StGo);
      game_over_q <= (state_q == StDone);
      hex_q       <= hex_for_state(state_q, timed_out_q);
      player_q    <= player_d;
    end
  end

  assign go_led_o        = go_led_q;
  assign game_over_o     = game_over_q;
  assign hex_mode_o      = hex_q;
  assign player_o        = player_q;
  assign reaction_time_o = rtime_q;
  assign scores_o        = scores_q;
  assign round_num_o     = round_q;

endmodule

// File: tb/tb_game1_reaction_multi.sv
// Scoreboard bench: stimulus pushes the expected display snapshot for each
// visible transition; the monitor pops and compares whenever the DUT's
// display mode / LED / game-over outputs change.
module tb_game1_reaction_multi;

  localparam int unsigned NP       = 2;
  localparam int unsigned TW       = 14;
  localparam int unsigned TICK     = 4;
  localparam int unsigned TMO      = 20;
  localparam int unsigned NROUNDS  = 3;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          switch_i;
  logic [NP-1:0] key_i;
  logic          go_led_o;
  logic [2:0]    hex_mode_o;
  logic [TW-1:0] reaction_time_o;
  logic          player_o;
  logic [7:0]    scores_o;
  logic [3:0]    round_num_o;
  logic          game_over_o;

  game1_reaction_multi #(
    .NUM_PLAYERS      (NP),
    .TIME_W           (TW),
    .TICK_DIV         (TICK),
    .DELAY_MIN_MS     (3),
    .DELAY_RANGE_LOG2 (2),
    .TIMEOUT_MS       (TMO),
    .ROUNDS           (NROUNDS)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .switch_i        (switch_i),
    .key_i           (key_i),
    .go_led_o        (go_led_o),
    .hex_mode_o      (hex_mode_o),
    .reaction_time_o (reaction_time_o),
    .player_o        (player_o),
    .scores_o        (scores_o),
    .round_num_o     (round_num_o),
    .game_over_o     (game_over_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          go;
    logic [2:0]    hex;
    logic          over;
    logic          player;
    logic [7:0]    scores;
    logic [3:0]    round;
    logic [TW-1:0] rt;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference game model
  int         m_sc[NP];
  int         m_round;
  int         m_rt;
  logic [2:0] m_hex;

  function automatic logic lowest(input logic [1:0] mask);
    return mask[0] ? 1'b0 : 1'b1;
  endfunction

  function automatic logic best_player();
    return (m_sc[1] > m_sc[0]) ? 1'b1 : 1'b0;
  endfunction

  task automatic push(input logic go, input logic [2:0] hex, input logic over, input logic pl);
    snap_t s;
    s.go     = go;
    s.hex    = hex;
    s.over   = over;
    s.player = pl;
    s.scores = {4'(m_sc[1]), 4'(m_sc[0])};
    s.round  = 4'(m_round);
    s.rt     = TW'(m_rt);
    exp_q.push_back(s);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drop the keys in mask for three clocks, then release and settle.
  task automatic press(input logic [1:0] mask);
    key_i = ~mask;
    repeat (3) @(negedge clk_i);
    key_i = '1;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic wait_hex(input logic [2:0] h, input int limit);
    int n = 0;
    while (hex_mode_o != h && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    chk("wait_hex_mode", int'(hex_mode_o), int'(h));
  endtask

  task automatic wait_go(input int limit);
    int n = 0;
    while (!go_led_o && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    chk("wait_go_led", int'(go_led_o), 1);
  endtask

  task automatic enter_arm(input logic [1:0] mask);
    if (m_hex != 3'b000) push(1'b0, 3'b000, 1'b0, 1'b0);
    press(mask);
    if (m_hex != 3'b000) wait_hex(3'b000, 20);
    m_hex = 3'b000;
  endtask

  // One round: enter ARM, optional false start, then a timed press in GO
  // (go_mask == 0 means let it time out). Finishes the game when due.
  task automatic play_round(input logic [1:0] arm_mask, input logic [1:0] foul_mask,
                            input logic [1:0] go_mask, input int r);
    logic w;
    enter_arm(arm_mask);
    if (foul_mask != 2'b00) begin
      push(1'b0, 3'b010, 1'b0, lowest(foul_mask));
      press(foul_mask);
      wait_hex(3'b010, 20);
      m_hex = 3'b010;
      enter_arm(2'($urandom_range(1, 3)));
    end
    push(1'b1, 3'b001, 1'b0, 1'b0);
    wait_go(200);
    if (go_mask != 2'b00) begin
      // go_led is first seen one clock after GO entry; three more clocks of
      // synchroniser latency land the press mid-way through timer value r.
      repeat (TICK * r - 2) @(negedge clk_i);
      w = lowest(go_mask);
      if (m_sc[w] < 15) m_sc[w]++;
      m_rt = r;
      m_round++;
      push(1'b0, 3'b100, 1'b0, w);
      press(go_mask);
      wait_hex(3'b100, 20);
      m_hex = 3'b100;
    end else begin
      m_rt = TMO;
      m_round++;
      push(1'b0, 3'b101, 1'b0, 1'b0);
      wait_hex(3'b101, TICK * TMO + 20);
      m_hex = 3'b101;
    end
    if (m_round == NROUNDS) begin
      push(1'b0, 3'b110, 1'b1, best_player());
      press(2'($urandom_range(1, 3)));
      wait_hex(3'b110, 20);
      m_sc[0] = 0;
      m_sc[1] = 0;
      m_round = 0;
      m_rt    = 0;
      push(1'b0, 3'b000, 1'b0, 1'b0);
      press(2'($urandom_range(1, 3)));
      wait_hex(3'b000, 20);
      m_hex = 3'b000;
    end
  endtask

  // Monitor: compare a full snapshot on each change of the display mode outputs.
  initial begin
    logic [4:0] prev_obs, cur_obs;
    snap_t      act, e;
    int         n = 0;
    prev_obs = '0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        prev_obs = '0;
        continue;
      end
      cur_obs = {go_led_o, hex_mode_o, game_over_o};
      if (cur_obs != prev_obs) begin
        prev_obs = cur_obs;
        n++;
        act = {go_led_o, hex_mode_o, game_over_o, player_o, scores_o, round_num_o,
               reaction_time_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL transition %0d: unexpected output go=%b hex=%b over=%b", n,
                   act.go, act.hex, act.over);
        end else begin
          e = exp_q.pop_front();
          if (act != e) begin
            errors++;
            $display("FAIL transition %0d: got go=%b hex=%b over=%b player=%0d scores=%h round=%0d rt=%0d, expected go=%b hex=%b over=%b player=%0d scores=%h round=%0d rt=%0d",
                     n, act.go, act.hex, act.over, act.player, act.scores, act.round, act.rt,
                     e.go, e.hex, e.over, e.player, e.scores, e.round, e.rt);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_sc[0] = 0;
    m_sc[1] = 0;
    m_round = 0;
    m_rt    = 0;
    m_hex   = 3'b000;
    reset_i  = 1'b1;
    switch_i = 1'b0;
    key_i    = '1;
    repeat (2) @(negedge clk_i);
    chk("reset_go_led", int'(go_led_o), 0);
    chk("reset_hex_mode", int'(hex_mode_o), 0);
    chk("reset_reaction_time", int'(reaction_time_o), 0);
    chk("reset_player", int'(player_o), 0);
    chk("reset_scores", int'(scores_o), 0);
    chk("reset_round_num", int'(round_num_o), 0);
    chk("reset_game_over", int'(game_over_o), 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    switch_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("idle_hex_mode", int'(hex_mode_o), 0);

    // Game 1: reaction 7 by player 1, foul then simultaneous press, timeout.
    play_round(2'b01, 2'b00, 2'b10, 7);
    play_round(2'b01, 2'b10, 2'b11, 5);
    play_round(2'b10, 2'b00, 2'b00, 0);

    // Game 2: player 1 takes two rounds and the game.
    play_round(2'b01, 2'b00, 2'b10, 3);
    play_round(2'b10, 2'b00, 2'b01, 4);
    play_round(2'b11, 2'b00, 2'b10, 9);

    // Randomised games.
    for (int g = 0; g < 3; g++) begin
      for (int rd = 0; rd < int'(NROUNDS); rd++) begin
        logic [1:0] fm, gm;
        fm = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
        gm = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        play_round(2'($urandom_range(1, 3)), fm, gm, int'($urandom_range(1, 15)));
      end
    end

    // Switch dropped mid-GO: scores clear next clock, LED drops after.
    play_round(2'b01, 2'b00, 2'b10, 2);
    enter_arm(2'b01);
    push(1'b1, 3'b001, 1'b0, 1'b0);
    wait_go(200);
    repeat (5) @(negedge clk_i);
    m_sc[0] = 0;
    m_sc[1] = 0;
    m_round = 0;
    push(1'b0, 3'b000, 1'b0, 1'b0);
    switch_i = 1'b0;
    @(negedge clk_i);
    chk("off_scores", int'(scores_o), 0);
    chk("off_round_num", int'(round_num_o), 0);
    @(negedge clk_i);
    chk("off_go_led", int'(go_led_o), 0);
    repeat (3) @(negedge clk_i);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
